// File: rtl/gx4000_pkg.sv
// Shared types and constants for the GX4000 sprite/playfield mixer.
package gx4000_pkg;

    typedef logic [11:0] rgb12_t;

    localparam logic [15:0] PAL_BASE    = 16'h6400;
    localparam logic [4:0]  BORDER_IDX  = 5'd16;
    localparam logic [4:0]  SPRITE_BASE = 5'd16;
    localparam int          PAL_DEPTH   = 32;
    localparam int          PAL_AW      = 5;

endpackage

// File: rtl/gx4000_palette_ram.sv
// 32x12 palette: one write port with separate {R,B} / G field enables and a
// registered read port.
module gx4000_palette_ram
    import gx4000_pkg::*;
(
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              we_rb,
    input  logic              we_g,
    input  logic [PAL_AW-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [PAL_AW-1:0] raddr,
    output rgb12_t            rdata
);

    logic [3:0] pal_r [PAL_DEPTH];
    logic [3:0] pal_g [PAL_DEPTH];
    logic [3:0] pal_b [PAL_DEPTH];

    // Storage carries no reset so it maps onto distributed RAM.
    always_ff @(posedge clk_sys) begin
        if (we_rb) begin
            pal_r[waddr] <= wdata[7:4];
            pal_b[waddr] <= wdata[3:0];
        end
        if (we_g) begin
            pal_g[waddr] <= wdata[3:0];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= {pal_r[raddr], pal_g[raddr], pal_b[raddr]};
        end
    end

endmodule

// File: rtl/gx4000_sprite_mixer.sv
// Pixel mixer: sprite/border/ink priority, palette lookup, collision capture.
// Collision logic is compiled in only when GX4000_MIX_COLLISION_EN is defined.
module gx4000_sprite_mixer
    import gx4000_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_wr,
    input  logic        asic_unlocked,
    input  logic [3:0]  pf_pen,
    input  logic        pf_border,
    input  logic [7:0]  sprite_pixel,
    input  logic        sprite_active,
    input  logic [3:0]  sprite_id,
    input  logic        hblank,
    input  logic        vblank,
    output rgb12_t      rgb_out,
    output logic        de_out,
    output logic [7:0]  coll_flags
);

    logic              pal_sel;
    logic              blank;
    logic [3:0]        spr_pen;
    logic              spr_hit;
    logic [PAL_AW-1:0] pix_idx;
    logic [PAL_AW-1:0] s1_idx;
    logic              s1_de;
    rgb12_t            pal_rdata;

    assign pal_sel = cpu_wr && asic_unlocked && (cpu_addr[15:6] == PAL_BASE[15:6]);
    assign blank   = hblank | vblank;
    assign spr_pen = sprite_pixel[3:0];
    assign spr_hit = sprite_active && (spr_pen != 4'd0);

    always_comb begin
        pix_idx = {1'b0, pf_pen};
        if (spr_hit) begin
            pix_idx = SPRITE_BASE + {1'b0, spr_pen};
        end else if (pf_border) begin
            pix_idx = BORDER_IDX;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            s1_idx <= '0;
            s1_de  <= 1'b0;
            de_out <= 1'b0;
        end else if (ce_pix) begin
            s1_idx <= pix_idx;
            s1_de  <= !blank;
            de_out <= s1_de;
        end
    end

    // Stage 2 read: a write landing on the same edge returns the old entry.
    gx4000_palette_ram u_palette (
        .clk_sys (clk_sys),
        .reset   (reset),
        .we_rb   (pal_sel && !cpu_addr[0]),
        .we_g    (pal_sel && cpu_addr[0]),
        .waddr   (cpu_addr[5:1]),
        .wdata   (cpu_data),
        .re      (ce_pix),
        .raddr   (s1_idx),
        .rdata   (pal_rdata)
    );

    assign rgb_out = de_out ? pal_rdata : 12'h000;

`ifdef GX4000_MIX_COLLISION_EN
    logic       vblank_d;
    logic       vblank_rise;
    logic [7:0] coll_work;
    logic       unused_bits;

    assign vblank_rise = vblank && !vblank_d;
    assign unused_bits = ^{sprite_pixel[7:4], sprite_id[3]};

    // Frame boundary clear takes precedence over a same-cycle hit.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vblank_d   <= 1'b0;
            coll_work  <= '0;
            coll_flags <= '0;
        end else begin
            vblank_d <= vblank;
            if (vblank_rise) begin
                coll_flags <= coll_work;
                coll_work  <= '0;
            end else if (ce_pix && !blank && spr_hit && !pf_border && (pf_pen != 4'd0)) begin
                coll_work[sprite_id[2:0]] <= 1'b1;
            end
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^{sprite_pixel[7:4], sprite_id};
    assign coll_flags  = 8'h00;
`endif

endmodule

// File: tb/tb_gx4000_sprite_mixer.sv
// Directed bench for gx4000_sprite_mixer; collision expectations follow
// GX4000_MIX_COLLISION_EN.
module tb_gx4000_sprite_mixer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ce_pix;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_wr;
    logic        asic_unlocked;
    logic [3:0]  pf_pen;
    logic        pf_border;
    logic [7:0]  sprite_pixel;
    logic        sprite_active;
    logic [3:0]  sprite_id;
    logic        hblank;
    logic        vblank;
    logic [11:0] rgb_out;
    logic        de_out;
    logic [7:0]  coll_flags;

    int n_pass = 0;
    int n_total = 0;

`ifdef GX4000_MIX_COLLISION_EN
    localparam logic [7:0] EXP_COLL_ID5 = 8'h20;
    localparam logic [7:0] EXP_COLL_ID0 = 8'h01;
`else
    localparam logic [7:0] EXP_COLL_ID5 = 8'h00;
    localparam logic [7:0] EXP_COLL_ID0 = 8'h00;
`endif

    always #5 clk_sys = ~clk_sys;

    gx4000_sprite_mixer dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ce_pix        (ce_pix),
        .cpu_addr      (cpu_addr),
        .cpu_data      (cpu_data),
        .cpu_wr        (cpu_wr),
        .asic_unlocked (asic_unlocked),
        .pf_pen        (pf_pen),
        .pf_border     (pf_border),
        .sprite_pixel  (sprite_pixel),
        .sprite_active (sprite_active),
        .sprite_id     (sprite_id),
        .hblank        (hblank),
        .vblank        (vblank),
        .rgb_out       (rgb_out),
        .de_out        (de_out),
        .coll_flags    (coll_flags)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_data = d;
        cpu_wr   = 1'b1;
        step(1);
        cpu_wr   = 1'b0;
    endtask

    task automatic set_pix(input logic [3:0] pen, input logic border,
                           input logic [7:0] spr, input logic act, input logic [3:0] id,
                           input logic hb, input logic vb);
        pf_pen        = pen;
        pf_border     = border;
        sprite_pixel  = spr;
        sprite_active = act;
        sprite_id     = id;
        hblank        = hb;
        vblank        = vb;
    endtask

    initial begin
        reset = 1'b1; ce_pix = 1'b0; cpu_addr = '0; cpu_data = '0; cpu_wr = 1'b0;
        asic_unlocked = 1'b1;
        set_pix(4'd0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk_sys);
        step(2);
        chk("reset_rgb", rgb_out, 12'h000);
        chk("reset_de", {11'd0, de_out}, 12'h000);
        chk("reset_coll", {4'd0, coll_flags}, 12'h000);
        reset = 1'b0;

        // Palette: entry1=53A, entry0=000, entry4=888, entry16=1F2, entry19=C74, entry31=9DB
        cpu_write(16'h6402, 8'h5A); cpu_write(16'h6403, 8'h03);
        cpu_write(16'h6400, 8'h00); cpu_write(16'h6401, 8'h00);
        cpu_write(16'h6408, 8'h88); cpu_write(16'h6409, 8'h08);
        cpu_write(16'h6420, 8'h12); cpu_write(16'h6421, 8'h0F);
        cpu_write(16'h6426, 8'hC4); cpu_write(16'h6427, 8'h07);
        cpu_write(16'h643E, 8'h9B); cpu_write(16'h643F, 8'h0D);

        ce_pix = 1'b1;
        set_pix(4'd1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        step(2);
        chk("pen1_rgb", rgb_out, 12'h53A);
        chk("pen1_de", {11'd0, de_out}, 12'h001);

        // Ignored writes: locked page, and addresses just outside the window
        asic_unlocked = 1'b0;
        cpu_write(16'h6402, 8'hFF);
        asic_unlocked = 1'b1;
        cpu_write(16'h6440, 8'hFF);
        cpu_write(16'h6441, 8'hFF);
        cpu_write(16'h63FF, 8'h0F);
        step(2);
        chk("locked_entry1", rgb_out, 12'h53A);
        set_pix(4'd0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        step(2);
        chk("oor_entry0", rgb_out, 12'h000);
        chk("pen0_de", {11'd0, de_out}, 12'h001);
        set_pix(4'd0, 1'b0, 8'h0F, 1'b1, 4'd0, 1'b0, 1'b0);
        step(2);
        chk("oor_entry31", rgb_out, 12'h9DB);

        // Priority
        set_pix(4'd1, 1'b0, 8'h03, 1'b1, 4'd0, 1'b0, 1'b0);
        step(2);
        chk("spr3_over_pen1", rgb_out, 12'hC74);
        set_pix(4'd1, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
        step(2);
        chk("spr0_transparent", rgb_out, 12'h53A);
        set_pix(4'd1, 1'b0, 8'h03, 1'b0, 4'd0, 1'b0, 1'b0);
        step(2);
        chk("spr_inactive", rgb_out, 12'h53A);
        set_pix(4'd1, 1'b0, 8'hF3, 1'b1, 4'd0, 1'b0, 1'b0);
        step(2);
        chk("spr_upper_bits", rgb_out, 12'hC74);

        // Border and blanking
        set_pix(4'd1, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        step(2);
        chk("border_rgb", rgb_out, 12'h1F2);
        set_pix(4'd1, 1'b1, 8'h03, 1'b1, 4'd0, 1'b0, 1'b0);
        step(2);
        chk("spr_over_border", rgb_out, 12'hC74);
        set_pix(4'd1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0);
        step(2);
        chk("hblank_rgb", rgb_out, 12'h000);
        chk("hblank_de", {11'd0, de_out}, 12'h000);
        set_pix(4'd1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        step(2);
        chk("post_blank_rgb", rgb_out, 12'h53A);

        // ce_pix gating, then exact two-cycle latency
        ce_pix = 1'b0;
        set_pix(4'd4, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0);
        step(3);
        chk("frozen_rgb", rgb_out, 12'h53A);
        chk("frozen_de", {11'd0, de_out}, 12'h001);
        ce_pix = 1'b1;
        set_pix(4'd4, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        step(2);
        chk("pen4_rgb", rgb_out, 12'h888);
        set_pix(4'd1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1);
        chk("latency_1", rgb_out, 12'h888);
        step(1);
        chk("latency_2", rgb_out, 12'h53A);

        // Write on the edge that reads entry 4: old value first, new value next
        set_pix(4'd4, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1);
        cpu_write(16'h6408, 8'h33);
        chk("rw_same_old", rgb_out, 12'h888);
        step(1);
        chk("rw_same_new", rgb_out, 12'h383);

        // Collision: only id5 qualifies
        set_pix(4'd4, 1'b0, 8'h02, 1'b1, 4'd5, 1'b0, 1'b0);
        step(1);
        set_pix(4'd0, 1'b0, 8'h02, 1'b1, 4'd2, 1'b0, 1'b0);
        step(1);
        set_pix(4'd4, 1'b1, 8'h02, 1'b1, 4'd3, 1'b0, 1'b0);
        step(1);
        set_pix(4'd4, 1'b0, 8'h02, 1'b1, 4'd1, 1'b1, 1'b0);
        step(1);
        set_pix(4'd4, 1'b0, 8'h00, 1'b1, 4'd6, 1'b0, 1'b0);
        step(1);
        chk("coll_before_vbl", {4'd0, coll_flags}, 12'h000);
        set_pix(4'd0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1);
        step(1);
        chk("coll_id5", {4'd0, coll_flags}, {4'd0, EXP_COLL_ID5});
        step(3);
        chk("coll_hold", {4'd0, coll_flags}, {4'd0, EXP_COLL_ID5});
        vblank = 1'b0;
        step(2);
        vblank = 1'b1;
        step(1);
        chk("coll_work_cleared", {4'd0, coll_flags}, 12'h000);

        // Mid-line reset with collision flags pending and ce_pix low
        vblank = 1'b0;
        step(1);
        set_pix(4'd1, 1'b0, 8'h05, 1'b1, 4'd0, 1'b0, 1'b0);
        step(1);
        set_pix(4'd1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1);
        step(1);
        set_pix(4'd1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        step(2);
        chk("pre_reset_coll", {4'd0, coll_flags}, {4'd0, EXP_COLL_ID0});
        chk("pre_reset_rgb", rgb_out, 12'h53A);
        ce_pix = 1'b0;
        reset  = 1'b1;
        step(1);
        chk("midrst_rgb", rgb_out, 12'h000);
        chk("midrst_de", {11'd0, de_out}, 12'h000);
        chk("midrst_coll", {4'd0, coll_flags}, 12'h000);
        reset  = 1'b0;
        ce_pix = 1'b1;
        step(2);
        chk("palette_kept", rgb_out, 12'h53A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
